// File: rtl/theta_slice_stage.sv
// Column-parity mixing stage: streams the slice memory once, writing each slice back with
// the column-parity correction applied. In-place safe: every slice is read before it is written.
module theta_slice_stage #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   input  logic [24:0]   rd_data,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [24:0]   wr_data,
   output logic          busy,
   output logic          done
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_PRE_READ = 3'd1;
   localparam logic [2:0] S_PRE_CAP  = 3'd2;
   localparam logic [2:0] S_READ     = 3'd3;
   localparam logic [2:0] S_WRITE    = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;

   localparam logic [AW-1:0] ZLAST = AW'(DEPTH - 1);

   if (DEPTH > (1 << AW)) begin : g_bad_params
      $error("AW too small for DEPTH");
   end

   logic [2:0]    state_q, state_d;
   logic [AW-1:0] z_q, z_d;
   logic [4:0]    cprev_q, cprev_d;

   function automatic logic [4:0] col_parity(input logic [24:0] s);
      return s[4:0] ^ s[9:5] ^ s[14:10] ^ s[19:15] ^ s[24:20];
   endfunction

   // cp is the column parity of slice z-1; the returned correction is replicated over all rows.
   function automatic logic [24:0] theta_slice(input logic [24:0] s, input logic [4:0] cp);
      logic [4:0] c;
      logic [4:0] d;
      c    = col_parity(s);
      d[0] = c[4] ^ cp[1];
      d[1] = c[0] ^ cp[2];
      d[2] = c[1] ^ cp[3];
      d[3] = c[2] ^ cp[4];
      d[4] = c[3] ^ cp[0];
      return s ^ {d, d, d, d, d};
   endfunction

   always_comb begin
      state_d = state_q;
      z_d     = z_q;
      cprev_d = cprev_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) state_d = S_PRE_READ;
         end
         S_PRE_READ: state_d = S_PRE_CAP;
         S_PRE_CAP: begin
            // Parity of the last slice, taken from original data, seeds slice 0.
            cprev_d = col_parity(rd_data);
            z_d     = '0;
            state_d = S_READ;
         end
         S_READ: state_d = S_WRITE;
         S_WRITE: begin
            cprev_d = col_parity(rd_data);
            if (z_q == ZLAST) begin
               state_d = S_DONE;
            end else begin
               z_d     = z_q + AW'(1);
               state_d = S_READ;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         z_q     <= '0;
         cprev_q <= '0;
      end else begin
         state_q <= state_d;
         z_q     <= z_d;
         cprev_q <= cprev_d;
      end
   end

   // Strobes decode straight from state so an asynchronous reset drops them at once.
   always_comb begin
      rd_en   = 1'b0;
      rd_addr = '0;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      done    = 1'b0;
      busy    = (state_q != S_IDLE);
      unique case (state_q)
         S_PRE_READ: begin
            rd_en   = 1'b1;
            rd_addr = ZLAST;
         end
         S_READ: begin
            rd_en   = 1'b1;
            rd_addr = z_q;
         end
         S_WRITE: begin
            wr_en   = 1'b1;
            wr_addr = z_q;
            wr_data = theta_slice(rd_data, cprev_q);
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_theta_slice_stage.sv
// Directed and random bench for theta_slice_stage with a behavioural slice memory.
module tb_theta_slice_stage;

   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic          clk;
   logic          rst;
   logic          start;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [24:0]   rd_data;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [24:0]   wr_data;
   logic          busy;
   logic          done;

   logic [24:0] mem     [DEPTH];
   logic [24:0] exp_mem [DEPTH];

   int n_vec;
   int n_err;

   theta_slice_stage #(
      .DEPTH(DEPTH),
      .AW   (AW)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .rd_en  (rd_en),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .wr_en  (wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .busy   (busy),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read memory; writes are applied by the run task when it sees wr_en.
   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

   typedef struct {
      int          z;
      logic [24:0] w;
      logic [24:0] e0;
      logic [24:0] e1;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk_mem(input string tag);
      for (int z = 0; z < DEPTH; z++)
         chk($sformatf("%s slice %0d", tag, z), 32'(mem[z]), 32'(exp_mem[z]));
   endtask

   task automatic clear_mem();
      for (int z = 0; z < DEPTH; z++) begin
         mem[z]     = '0;
         exp_mem[z] = '0;
      end
   endtask

   // Whole-state reference: column parities first, then correct every lane.
   task automatic theta_ref();
      logic [4:0] c [DEPTH];
      for (int z = 0; z < DEPTH; z++)
         for (int x = 0; x < 5; x++) begin
            c[z][x] = 1'b0;
            for (int y = 0; y < 5; y++) c[z][x] = c[z][x] ^ mem[z][5*y+x];
         end
      for (int z = 0; z < DEPTH; z++)
         for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
               exp_mem[z][5*y+x] = mem[z][5*y+x] ^ c[z][(x+4)%5] ^ c[(z+DEPTH-1)%DEPTH][(x+1)%5];
   endtask

   // Starts a run and monitors it at negedges; cycle 0 is the cycle after the start edge.
   task automatic do_run(input string tag, input bit repulse, input bit hold, input int abort_at);
      int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, done_cyc = -1, first_rd = -1;
      bit order_err = 0, time_err = 0, overlap = 0, strobe_err = 0, busy_err = 0;
      bit finished = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      if (!hold) start = 1'b0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         if (rd_en && wr_en) overlap = 1;
         if (!rd_en && rd_addr != '0) strobe_err = 1;
         if (!wr_en && (wr_addr != '0 || wr_data != '0)) strobe_err = 1;
         if (rd_en) begin
            if (rd_cnt == 0) first_rd = int'(rd_addr);
            rd_cnt++;
         end
         if (wr_en) begin
            if (int'(wr_addr) != wr_cnt) order_err = 1;
            if (cyc != 3 + 2 * wr_cnt) time_err = 1;
            mem[wr_addr] = wr_data;
            wr_cnt++;
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (done_cyc >= 0 && cyc == done_cyc + 1) begin
            chk({tag, " busy low after done"}, 32'(busy), 32'(0));
            finished = 1;
            break;
         end else if (!busy) begin
            busy_err = 1;
         end
         if (cyc == abort_at) begin
            #1 rst = 1'b0;
            #1;
            chk({tag, " abort wr_en"}, 32'(wr_en), 32'(0));
            chk({tag, " abort rd_en"}, 32'(rd_en), 32'(0));
            chk({tag, " abort busy"}, 32'(busy), 32'(0));
            chk({tag, " abort writes before"}, 32'(wr_cnt), 32'(21));
            return;
         end
         if (!hold) start = repulse && (cyc == 10 || cyc == 50);
         @(negedge clk);
      end
      if (!hold) start = 1'b0;
      chk({tag, " run finished"}, 32'(finished), 32'(1));
      chk({tag, " write count"}, 32'(wr_cnt), 32'(DEPTH));
      chk({tag, " read count"}, 32'(rd_cnt), 32'(DEPTH + 1));
      chk({tag, " done pulses"}, 32'(done_cnt), 32'(1));
      chk({tag, " done cycle"}, 32'(done_cyc), 32'(2 + 2 * DEPTH));
      chk({tag, " first read addr"}, 32'(first_rd), 32'(DEPTH - 1));
      chk({tag, " write order"}, 32'(order_err), 32'(0));
      chk({tag, " write timing"}, 32'(time_err), 32'(0));
      chk({tag, " rd/wr overlap"}, 32'(overlap), 32'(0));
      chk({tag, " idle strobes"}, 32'(strobe_err), 32'(0));
      chk({tag, " busy during run"}, 32'(busy_err), 32'(0));
   endtask

   initial begin
      vec_t vt [6];
      bit   quiet_err;
      logic [31:0] r;
      n_vec = 0;
      n_err = 0;
      rst   = 1'b0;
      start = 1'b0;
      clear_mem();

      vt[0] = '{z: 0,  w: 25'h0000000, e0: 25'h0000000, e1: 25'h0000000};
      vt[1] = '{z: 0,  w: 25'h0000001, e0: 25'h0210843, e1: 25'h1084210};
      vt[2] = '{z: 63, w: 25'h0000001, e0: 25'h0210843, e1: 25'h1084210};
      vt[3] = '{z: 10, w: 25'h1000000, e0: 25'h1108421, e1: 25'h0842108};
      vt[4] = '{z: 31, w: 25'h0000021, e0: 25'h0000021, e1: 25'h0000000};
      vt[5] = '{z: 5,  w: 25'h1FFFFFF, e0: 25'h0000000, e1: 25'h1FFFFFF};

      #1;
      chk("reset busy", 32'(busy), 32'(0));
      chk("reset done", 32'(done), 32'(0));
      chk("reset rd_en", 32'(rd_en), 32'(0));
      chk("reset wr_en", 32'(wr_en), 32'(0));
      chk("reset rd_addr", 32'(rd_addr), 32'(0));
      chk("reset wr_addr", 32'(wr_addr), 32'(0));
      chk("reset wr_data", 32'(wr_data), 32'(0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 6; i++) begin
         clear_mem();
         mem[vt[i].z]                   = vt[i].w;
         exp_mem[vt[i].z]               = vt[i].e0;
         exp_mem[(vt[i].z + 1) % DEPTH] = vt[i].e1;
         do_run($sformatf("vec%0d", i), 1'b0, 1'b0, -1);
         chk_mem($sformatf("vec%0d", i));
      end

      // start re-pulsed while busy must be ignored
      clear_mem();
      mem[0] = 25'h0000001;
      exp_mem[0] = 25'h0210843;
      exp_mem[1] = 25'h1084210;
      do_run("repulse", 1'b1, 1'b0, -1);
      chk_mem("repulse");

      // start held high: one IDLE cycle, then a fresh run from the last slice
      clear_mem();
      do_run("hold", 1'b0, 1'b1, -1);
      @(negedge clk);
      chk("hold restart busy", 32'(busy), 32'(1));
      chk("hold restart rd_en", 32'(rd_en), 32'(1));
      chk("hold restart rd_addr", 32'(rd_addr), 32'(DEPTH - 1));
      start = 1'b0;
      #1 rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      // asynchronous reset during the write of slice 20
      clear_mem();
      mem[3] = 25'h0000001;
      do_run("abort", 1'b0, 1'b0, 3 + 2 * 20);
      @(negedge clk);
      rst = 1'b1;
      quiet_err = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (wr_en || done || busy) quiet_err = 1;
      end
      chk("abort quiet after reset", 32'(quiet_err), 32'(0));
      clear_mem();
      mem[10]     = 25'h1000000;
      exp_mem[10] = 25'h1108421;
      exp_mem[11] = 25'h0842108;
      do_run("post-abort", 1'b0, 1'b0, -1);
      chk_mem("post-abort");

      // random state, two chained runs
      for (int z = 0; z < DEPTH; z++) begin
         r      = $urandom();
         mem[z] = r[24:0];
      end
      for (int pass = 0; pass < 2; pass++) begin
         theta_ref();
         do_run($sformatf("rand%0d", pass), 1'b0, 1'b0, -1);
         chk_mem($sformatf("rand%0d", pass));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/theta_slice_stage.md
Name: theta_slice_stage

Overview:
- Column-parity mixing stage of the permutation datapath; sits directly upstream of the index/rotation controller stage.
- Walks the 64 slice words of the 25-bit-per-slice state memory and writes each slice back with the column-parity correction applied.
- The downstream controller starts only after this block's done pulse.
- Supports in-place operation: the read and write ports may target the same memory.

Parameters:
DEPTH, 64, number of slices (z dimension); slice indices 0..DEPTH-1
AW, 6, slice address width; must satisfy 2^AW >= DEPTH

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  start request, sampled in IDLE only
rd_en  output  1  memory read strobe
rd_addr  output  AW  slice address being read
rd_data  input  25  slice word, valid the cycle after rd_en (synchronous read)
wr_en  output  1  memory write strobe
wr_addr  output  AW  slice address being written
wr_data  output  25  corrected slice word
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- Slice bit mapping: bit (5*y + x) holds lane (x,y), with x,y in 0..4.
- Column parity: C[x] = XOR over y of bit(5*y+x).
- Correction: D[x][z] = C[x-1 mod 5][z] ^ C[x+1 mod 5][z-1 mod DEPTH].
- Output: out[5*y+x] = in[5*y+x] ^ D[x][z].
- Internal registers: z counter (AW bits), cprev (5 bits, C of slice z-1).
- Reset (rst=0, asynchronous): state=IDLE, z=0, cprev=0; rd_en, wr_en, busy and done all 0; rd_addr, wr_addr and wr_data all 0.
- FSM states: IDLE, PRE_READ, PRE_CAP, READ, WRITE, DONE.
- IDLE: stays while start=0; start=1 -> PRE_READ.
- PRE_READ: rd_en=1, rd_addr=DEPTH-1 -> PRE_CAP.
- PRE_CAP: cprev <= C(rd_data); z <= 0 -> READ. This is the wrap-around source for slice 0.
- READ: rd_en=1, rd_addr=z -> WRITE.
- WRITE: wr_en=1, wr_addr=z, wr_data=corrected rd_data computed combinationally from rd_data and cprev.
  - Same edge: cprev <= C(rd_data) of the uncorrected input.
  - If z == DEPTH-1 -> DONE; else z <= z+1 -> READ.
- DONE: done=1 for exactly one cycle -> IDLE.
- Latency: if start is sampled at edge k, WRITE of slice z occupies the cycle after edge k+3+2z; done is high during the cycle after edge k+2+2*DEPTH (edge k+130 for DEPTH=64).
- Memory traffic: exactly DEPTH+1 reads and DEPTH writes per run, in ascending z order.
- rd_en and wr_en are never high in the same cycle.
- In-place safety: slice z is always read before it is written, and its parity is captured from the pre-write data, so writes do not corrupt later results.
- The slice DEPTH-1 parity used for slice 0 comes from the original data.
- start while busy: ignored, no restart or queueing. start held high through DONE starts a new run at the edge leaving DONE->IDLE plus one (IDLE must be visited for one cycle).
- z wrap: z never exceeds DEPTH-1; the counter does not overflow into a second pass.
- Reset mid-run: immediate return to IDLE with all strobes low, no done pulse, and no further writes. Memory contents are partially updated and are not this block's concern.
- Outputs rd_addr and wr_addr hold 0 when their strobe is low. wr_data is 0 when wr_en=0.

Test Plan:
- All-zero memory, start pulse -> 64 writes of 0x0000000 to addresses 0..63 in order; done exactly one cycle, at the cycle after edge k+130; busy high throughout, then low.
- Slice 0 = 0x0000001, all others 0 -> slice 0 = 0x0210843, slice 1 = 0x1084210, all other slices 0.
- Wrap-around: slice 63 = 0x0000001, others 0 -> slice 63 = 0x0210843, slice 0 = 0x1084210, others 0; the first read address is 63.
- start re-pulsed at cycles 10 and 50 of a run -> write count stays 64 and a single done pulse; an identical second run starts only after IDLE is visited.
- rst=0 asserted asynchronously mid-cycle during WRITE of slice 20 -> wr_en, rd_en and busy drop immediately; no done; no writes until the next start; the next run completes normally with correct results.
- Random memory, two back-to-back runs -> each run's output matches the reference theta model applied to that run's input state; the second run uses the first run's output as its input.
